// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Holds the funct3 encodings, FSM states, iteration count and request payload.
package mdu_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PROD_W     = 2 * XLEN;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);
  localparam int unsigned RADDR_W    = 5;
  localparam int unsigned F3_W       = 3;

  typedef enum logic [F3_W-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  typedef struct packed {
    mdu_op_e              op;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [RADDR_W-1:0]   rd_addr;
  } mdu_req_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? ((~x) + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> MDU handshake bundle: request in, stall/writeback out.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic                 start_i;
  logic [F3_W-1:0]      funct3_i;
  logic [XLEN-1:0]      op1_i;
  logic [XLEN-1:0]      op2_i;
  logic [RADDR_W-1:0]   rd_addr_i;
  logic                 flush_i;
  logic                 hold_flag_o;
  logic                 busy_o;
  logic                 valid_o;
  logic [RADDR_W-1:0]   rd_addr_o;
  logic [XLEN-1:0]      rd_data_o;
  logic                 rd_wen_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  hold_flag_o, busy_o, valid_o, rd_addr_o, rd_data_o, rd_wen_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
    output hold_flag_o, busy_o, valid_o, rd_addr_o, rd_data_o, rd_wen_o
  );
endinterface

// File: rtl/mdu_iter.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply or restoring divide.
// {hi,lo} holds the 64-bit product, or remainder (hi) and quotient (lo).
module mdu_iter
  import mdu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q,  b_d;
  logic            div_q, div_d;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  // Partial remainder is always below the divisor, so the 32-bit wrapped
  // difference is exact whenever the subtraction is taken.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_sub   = div_shift[XLEN-1:0] - b_q;

    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;

    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
    end else if (step_i) begin
      if (div_q) begin
        hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], div_ge};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M multiply/divide sequencer: accepts a request, runs 32 iterations in
// mdu_iter (or short-circuits div-by-zero/overflow), applies signs, writes back.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mdu_ctrl_if.slave bus
);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mdu_op_e            op_q, op_d;
  logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic               neg_q, neg_d;
  logic               byp_q, byp_d;
  logic [XLEN-1:0]    byp_data_q, byp_data_d;

  mdu_req_t           req_c;
  logic               accept_c;
  logic               a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0]    a_mag_c, b_mag_c;
  logic               div0_c, ovf_c, neg_c;
  logic [XLEN-1:0]    byp_val_c;
  logic               iter_load_c, iter_step_c;
  logic [XLEN-1:0]    iter_hi, iter_lo;
  logic [PROD_W-1:0]  prod_c, prod_s_c;
  logic [XLEN-1:0]    result_c;
  logic               done_c;

  assign req_c = '{op:      mdu_op_e'(bus.funct3_i),
                   op1:     bus.op1_i,
                   op2:     bus.op2_i,
                   rd_addr: bus.rd_addr_i};

  assign accept_c = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;

  // Operand decode: signedness, magnitudes, special cases and result sign.
  always_comb begin
    a_signed_c = (req_c.op == OP_MULH) || (req_c.op == OP_MULHSU) ||
                 (req_c.op == OP_DIV)  || (req_c.op == OP_REM);
    b_signed_c = (req_c.op == OP_MULH) || (req_c.op == OP_DIV) || (req_c.op == OP_REM);
    a_neg_c    = a_signed_c && req_c.op1[XLEN-1];
    b_neg_c    = b_signed_c && req_c.op2[XLEN-1];
    a_mag_c    = cond_neg(req_c.op1, a_neg_c);
    b_mag_c    = cond_neg(req_c.op2, b_neg_c);

    div0_c = req_c.op[2] && (req_c.op2 == '0);
    ovf_c  = ((req_c.op == OP_DIV) || (req_c.op == OP_REM)) &&
             (req_c.op1 == {1'b1, (XLEN-1)'(0)}) && (req_c.op2 == '1);

    neg_c = 1'b0;
    case (req_c.op)
      OP_MULH, OP_MULHSU, OP_DIV: neg_c = a_neg_c ^ b_neg_c;
      OP_REM:                     neg_c = a_neg_c;
      default:                    neg_c = 1'b0;
    endcase

    byp_val_c = '0;
    if (div0_c) begin
      byp_val_c = req_c.op[1] ? req_c.op1 : '1;
    end else if (ovf_c) begin
      byp_val_c = (req_c.op == OP_DIV) ? {1'b1, (XLEN-1)'(0)} : '0;
    end
  end

  // Next-state and sequencing; flush wins over everything except reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_addr_d   = rd_addr_q;
    neg_d       = neg_q;
    byp_d       = byp_q;
    byp_data_d  = byp_data_q;
    iter_load_c = 1'b0;
    iter_step_c = 1'b0;

    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            op_d       = req_c.op;
            rd_addr_d  = req_c.rd_addr;
            neg_d      = neg_c;
            cnt_d      = '0;
            byp_d      = div0_c || ovf_c;
            byp_data_d = byp_val_c;
            if (div0_c || ovf_c) begin
              state_d = S_DONE;
            end else begin
              iter_load_c = 1'b1;
              state_d     = S_CALC;
            end
          end
        end
        S_CALC: begin
          iter_step_c = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      rd_addr_q  <= '0;
      neg_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_addr_q  <= rd_addr_d;
      neg_q      <= neg_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  mdu_iter u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (iter_load_c),
    .step_i (iter_step_c),
    .div_i  (req_c.op[2]),
    .a_i    (a_mag_c),
    .b_i    (b_mag_c),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo)
  );

  // Sign fix-up of the magnitude result, selected by the captured opcode.
  always_comb begin
    prod_c   = {iter_hi, iter_lo};
    prod_s_c = neg_q ? ((~prod_c) + PROD_W'(1)) : prod_c;
    case (op_q)
      OP_MUL:                        result_c = prod_s_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_c = prod_s_c[PROD_W-1:XLEN];
      OP_DIV, OP_DIVU:               result_c = cond_neg(iter_lo, neg_q);
      OP_REM, OP_REMU:               result_c = cond_neg(iter_hi, neg_q);
      default:                       result_c = '0;
    endcase
    if (byp_q) begin
      result_c = byp_data_q;
    end
  end

  assign done_c          = (state_q == S_DONE);
  assign bus.valid_o     = done_c;
  assign bus.rd_wen_o    = done_c;
  assign bus.rd_addr_o   = done_c ? rd_addr_q : '0;
  assign bus.rd_data_o   = done_c ? result_c : '0;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.hold_flag_o = accept_c || (state_q == S_CALC);

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit XLEN.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start_i  input  1  execute stage requests an M-extension operation this cycle.
REQ-006 funct3_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op1_i / op2_i  input  32  rs1 / rs2 operand values.
REQ-008 rd_addr_i  input  5  destination register of the request.
REQ-009 flush_i  input  1  pipeline flush from ctrl (taken jump); aborts the operation.
REQ-010 hold_flag_o  output  1  stall request to ctrl.
REQ-011 busy_o  output  1  state is not IDLE.
REQ-012 valid_o  output  1  one-cycle result strobe.
REQ-013 rd_addr_o  output  5  captured destination register.
REQ-014 rd_data_o  output  32  result.
REQ-015 rd_wen_o  output  1  equals valid_o.

Function
REQ-016 FSM states SHALL be IDLE, CALC and DONE, with state register reset to IDLE.
REQ-017 In IDLE with start_i=1 and flush_i=0, the block SHALL capture operands, funct3_i and rd_addr_i, and move to CALC next cycle with cnt=0.
REQ-018 The block SHALL ignore start_i in CALC and DONE (no queuing).
REQ-019 In CALC, the block SHALL perform one iteration per cycle: shift-add multiply or restoring divide on magnitudes, with cnt incrementing 0..31; after cnt=31 it moves to DONE.
REQ-020 The DONE state SHALL last exactly one cycle: valid_o=1, rd_wen_o=1, then return to IDLE.
REQ-021 Latency: start_i accepted at cycle N; valid_o SHALL be high in cycle N+33.
REQ-022 Divide by zero SHALL bypass CALC and go IDLE->DONE directly, with valid_o in cycle N+1: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU remainder = op1.
REQ-023 Signed overflow (DIV/REM with op1=0x80000000, op2=0xFFFFFFFF) SHALL bypass CALC with valid_o in cycle N+1: DIV result 0x80000000, REM result 0.
REQ-024 Sign rules: MUL SHALL return the low 32 bits of the 64-bit product; MULH signed x signed, MULHSU signed x unsigned and MULHU unsigned x unsigned SHALL return the high 32 bits.
REQ-025 Sign rules: the quotient sign SHALL be op1 sign XOR op2 sign; the remainder sign SHALL equal the dividend sign; signs are applied in DONE.
REQ-026 hold_flag_o SHALL be (IDLE and start_i and not flush_i) OR CALC; it is 0 in DONE so the pipeline advances with the writeback.
REQ-027 flush_i=1 in any state SHALL force IDLE next cycle with valid_o=0 and no writeback; a flush in the same cycle as start_i prevents acceptance.
REQ-028 Outside DONE, rd_addr_o, rd_data_o, valid_o and rd_wen_o SHALL be 0.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL set state to IDLE, cnt to 0, and all datapath registers and outputs to 0.
REQ-030 Reset during CALC SHALL discard the operation with no valid_o pulse; the first cycle after reset accepts start_i.

Structure
REQ-031 funct3 encodings, state encodings and the value 32 iteration count SHALL live in the shared defines.v.
REQ-032 FSM, counter and sequencing SHALL reside in mdu_ctrl; the iterative shift/subtract datapath SHALL be one sub-module, mdu_iter, controlled by load/step strobes.

Verification
REQ-033 The bench SHALL cover MUL with op1=7, op2=0xFFFFFFFA (-6) -> valid_o in cycle N+33, rd_data_o=0xFFFFFFD6, hold_flag_o high N..N+32.
REQ-034 The bench SHALL cover MULHU with op1=op2=0xFFFFFFFF -> rd_data_o=0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-035 The bench SHALL cover DIV with op1=-7, op2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-036 The bench SHALL cover DIVU with op2=0 -> valid_o in N+1, 0xFFFFFFFF; REM with op1=0x80000000, op2=-1 -> valid_o in N+1, rd_data_o=0.
REQ-037 The bench SHALL cover flush_i pulsed at CALC cnt=10 -> IDLE next cycle, no valid_o, and a new start is accepted the following cycle.
REQ-038 The bench SHALL cover rst_n low for one cycle mid-CALC -> all outputs 0, busy_o=0, and no stale valid_o afterwards.
